// File: rtl/hack_ctrl_pkg.sv
// rtl/hack_ctrl_pkg.sv - shared state encoding and Hack instruction field indices.
package hack_ctrl_pkg;

`ifdef HACK_SELF_LOOP_HALT_EN
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, FAULT, HALT} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, FAULT} state_t;
`endif

  localparam int J_LT  = 2;
  localparam int J_EQ  = 1;
  localparam int J_GT  = 0;
  localparam int C_BIT = 15;

endpackage

// File: rtl/hack_jump_eval.sv
// rtl/hack_jump_eval.sv - combinational Hack jump-condition decode against ALU flags.
module hack_jump_eval
  import hack_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        zr,
  input  logic        ng,
  output logic        jump_taken
);

  assign jump_taken = instr[C_BIT] &
                      ((instr[J_LT] & ng) |
                       (instr[J_EQ] & zr) |
                       (instr[J_GT] & ~ng & ~zr));

endmodule

// File: rtl/hack_pc_sequencer.sv
// rtl/hack_pc_sequencer.sv - fetch/execute PC sequencer; HACK_SELF_LOOP_HALT_EN adds self-loop halt.
module hack_pc_sequencer
  import hack_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      pc,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  output logic [15:0]      instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             alu_zr,
  input  logic             alu_ng,
  input  logic [15:0]      jmp_target,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             fault,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] to_cnt;
  logic       jump_q;
  logic       jump_taken;
  logic       self_loop;
  logic       retire_now;

  hack_jump_eval u_jump_eval (
    .instr      (instr),
    .zr         (alu_zr),
    .ng         (alu_ng),
    .jump_taken (jump_taken)
  );

`ifdef HACK_SELF_LOOP_HALT_EN
  assign self_loop = jump_taken & (jmp_target == pc);
  assign halted    = (state == HALT);
`else
  logic unused_inputs;
  assign unused_inputs = ^{pc, jmp_target};
  assign self_loop     = 1'b0;
  assign halted        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      instr      <= '0;
      to_cnt     <= '0;
      jump_q     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) begin
        if (imem_ack) begin
          instr  <= imem_data;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end
      if (state == EXEC && exec_done) jump_q <= jump_taken;
      if (retire_now) retire_cnt <= retire_cnt + 1'b1;
    end
  end

  // A halting self-loop retires on entry to HALT since it never passes through UPDATE.
  always_comb begin
    state_nxt  = state;
    retire_now = 1'b0;
    case (state)
      IDLE:   if (run) state_nxt = FETCH;
      FETCH: begin
        if (imem_ack)               state_nxt = EXEC;
        else if (to_cnt == TO_LAST) state_nxt = FAULT;
      end
      EXEC: begin
        if (exec_done) begin
`ifdef HACK_SELF_LOOP_HALT_EN
          if (self_loop) begin
            state_nxt  = HALT;
            retire_now = 1'b1;
          end else begin
            state_nxt = UPDATE;
          end
`else
          state_nxt = self_loop ? FAULT : UPDATE;
`endif
        end
      end
      UPDATE: begin
        retire_now = 1'b1;
        state_nxt  = run ? FETCH : IDLE;
      end
      FAULT:  state_nxt = FAULT;
`ifdef HACK_SELF_LOOP_HALT_EN
      HALT:   state_nxt = HALT;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign pc_load     = (state == UPDATE) &  jump_q;
  assign pc_inc      = (state == UPDATE) & ~jump_q;
  assign fault       = (state == FAULT);

endmodule

// File: tb/tb_hack_pc_sequencer.sv
// tb/tb_hack_pc_sequencer.sv - self-checking bench for hack_pc_sequencer.
module tb_hack_pc_sequencer;

  localparam int TO    = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, run, imem_ack, exec_done, alu_zr, alu_ng;
  logic [15:0]      pc, imem_data, jmp_target;
  logic             imem_req, instr_valid, pc_inc, pc_load, fault, halted;
  logic [15:0]      instr;
  logic [CNT_W-1:0] retire_cnt;

  logic [15:0] je_instr;
  logic        je_zr, je_ng, je_out;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  hack_pc_sequencer #(.FETCH_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .pc(pc),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .jmp_target(jmp_target),
    .pc_inc(pc_inc), .pc_load(pc_load), .fault(fault), .halted(halted),
    .retire_cnt(retire_cnt)
  );

  hack_jump_eval u_jump_ref (.instr(je_instr), .zr(je_zr), .ng(je_ng), .jump_taken(je_out));

  typedef struct {
    logic [15:0] instr;
    logic        zr;
    logic        ng;
    logic        exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected behaviour from the ALU result value itself, not from the flag bits.
  task automatic do_instr(input logic [15:0] word, input int ack_wait, input int exec_wait,
                          input logic signed [15:0] res, input logic [15:0] tgt, input bit stop);
    bit exp_jump, exp_halt;
    exp_jump = word[15] && ((res < 0 && word[2]) || (res == 0 && word[1]) || (res > 0 && word[0]));
    exp_halt = 1'b0;
`ifdef HACK_SELF_LOOP_HALT_EN
    exp_halt = exp_jump && (tgt == pc);
`endif
    chk("fetch_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < ack_wait; k++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("fetch_wait_req", 32'(imem_req), 32'd1);
    end
    imem_ack  = 1'b1;
    imem_data = word;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("instr", 32'(instr), 32'(word));
    chk("exec_no_req", 32'(imem_req), 32'd0);
    if (stop) run = 1'b0;
    repeat (exec_wait) begin
      @(negedge clk);
      chk("exec_hold", 32'(instr_valid), 32'd1);
    end
    exec_done  = 1'b1;
    alu_zr     = (res == 0);
    alu_ng     = (res < 0);
    jmp_target = tgt;
    @(negedge clk);
    exec_done  = 1'b0;
    alu_zr     = 1'($urandom);
    alu_ng     = 1'($urandom);
    jmp_target = 16'($urandom);
    chk("pc_load", 32'(pc_load), 32'(exp_jump && !exp_halt));
    chk("pc_inc", 32'(pc_inc), 32'(!exp_jump && !exp_halt));
    chk("halted", 32'(halted), 32'(exp_halt));
    model_cnt++;
    if (!exp_halt) pc = exp_jump ? tgt : pc + 16'd1;
    @(negedge clk);
    chk("retire_cnt", 32'(retire_cnt), 32'(model_cnt % (1 << CNT_W)));
    chk("pulse_width", 32'(pc_inc | pc_load), 32'd0);
    chk("next_req", 32'(imem_req), 32'(!exp_halt && run));
  endtask

  task automatic restart();
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    model_cnt = 0;
    @(negedge clk);
  endtask

  initial begin
    logic signed [15:0] res;
    logic [15:0] tgt;
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    alu_zr = 1'b0; alu_ng = 1'b0; pc = 16'h0000; imem_data = 16'h0; jmp_target = 16'h0;
    je_instr = 16'h0; je_zr = 1'b0; je_ng = 1'b0;

    // Jump truth table: j bit 2 covers negative, bit 1 zero, bit 0 positive.
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 3; c++) begin
        vec_t v;
        v.instr = 16'hE000 | 16'(j) | 16'($urandom_range(0, 1023) << 3);
        v.ng    = (c == 0);
        v.zr    = (c == 1);
        v.exp   = (c == 0) ? v.instr[2] : (c == 1) ? v.instr[1] : v.instr[0];
        tbl.push_back(v);
        v.instr = 16'h0007 | 16'(j << 8);
        v.exp   = 1'b0;
        tbl.push_back(v);
      end
    end
    foreach (tbl[i]) begin
      je_instr = tbl[i].instr;
      je_zr    = tbl[i].zr;
      je_ng    = tbl[i].ng;
      #1;
      chk("jump_table", 32'(je_out), 32'(tbl[i].exp));
    end

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pulses", 32'({pc_inc, pc_load}), 32'd0);
    chk("rst_flags", 32'({fault, halted}), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_cnt", 32'(retire_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", 32'(imem_req), 32'd0);
    run = 1'b1;
    @(negedge clk);

    do_instr(16'h0005, 0, 0, 16'sd7, 16'h1234, 1'b0);
    do_instr(16'hE302, 0, 0, 16'sd0, 16'h0040, 1'b0);
    do_instr(16'hE302, 1, 2, 16'sd5, 16'h0080, 1'b0);
    do_instr(16'hE302, TO - 1, 0, 16'sd5, 16'h0080, 1'b0);
    chk("late_ack_no_fault", 32'(fault), 32'd0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       res = -16'(signed'($urandom_range(1, 30000)));
        1:       res = 16'sd0;
        default: res = 16'(signed'($urandom_range(1, 30000)));
      endcase
      tgt = 16'($urandom);
      if (tgt == pc) tgt = tgt ^ 16'h0001;
      do_instr(16'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, 3), res, tgt, 1'b0);
    end

    do_instr(16'hE307, 0, 1, 16'sd3, 16'h0200, 1'b1);
    @(negedge clk);
    chk("stop_idle", 32'(imem_req), 32'd0);
    chk("stop_no_pulse", 32'({pc_inc, pc_load}), 32'd0);
    run = 1'b1;
    @(negedge clk);
    chk("resume_req", 32'(imem_req), 32'd1);

    pc = 16'h0010;
    do_instr(16'hEA87, 0, 0, 16'sd0, 16'h0010, 1'b0);
    @(negedge clk);
`ifdef HACK_SELF_LOOP_HALT_EN
    chk("halt_sticky", 32'({halted, imem_req}), 32'b10);
`else
    chk("selfloop_refetch", 32'({halted, imem_req}), 32'b01);
`endif

    restart();
    imem_ack  = 1'b1;
    imem_data = 16'hFC10;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mid_exec_valid", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", 32'({imem_req, instr_valid, pc_inc, pc_load, fault, halted}), 32'd0);
    chk("mid_rst_cnt", 32'(retire_cnt), 32'd0);
    chk("mid_rst_instr", 32'(instr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_idle", 32'(imem_req), 32'd0);

    run = 1'b1;
    model_cnt = 0;
    @(negedge clk);
    for (int n = 0; n < (1 << CNT_W); n++) do_instr(16'h0001, 0, 0, 16'sd1, 16'h0, 1'b0);
    chk("wrap_zero", 32'(retire_cnt), 32'd0);

    restart();
    for (int k = 0; k < TO; k++) begin
      chk("to_req", 32'(imem_req), 32'd1);
      chk("to_no_fault", 32'(fault), 32'd0);
      @(negedge clk);
    end
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_req_drop", 32'({imem_req, instr_valid}), 32'd0);
    repeat (3) @(negedge clk);
    chk("fault_sticky", 32'({fault, imem_req}), 32'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("fault_cleared", 32'(fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_pc_sequencer.md
Name: hack_pc_sequencer

Overview:
- Fetch/execute controller that sequences the 16-bit program counter of the Hack-style CPU.
- Issues instruction-memory fetches at the current PC and hands each fetched word to the execute stage.
- Evaluates Hack jump bits against ALU flags, then pulses exactly one of the PC's inc/load controls per retired instruction.
- Sits between instruction ROM, PC and ALU/execute stage.

Parameters:
- FETCH_TIMEOUT, 15, number of FETCH cycles without imem_ack before entering FAULT (legal range 2..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high.
- run  in  1  level; 1 = keep executing, 0 = stop after the current instruction.
- pc  in  16  current PC counter value.
- imem_req  out  1  fetch request; the address is pc.
- imem_ack  in  1  ROM data valid this cycle.
- imem_data  in  16  instruction word.
- instr  out  16  latched instruction.
- instr_valid  out  1  instr is presented to the execute stage.
- exec_done  in  1  execute stage finished; alu_zr/alu_ng are valid.
- alu_zr  in  1  ALU result zero.
- alu_ng  in  1  ALU result negative.
- jmp_target  in  16  A-register value, the PC load source.
- pc_inc  out  1  one-cycle increment pulse to the PC.
- pc_load  out  1  one-cycle load pulse to the PC; the PC loads jmp_target.
- fault  out  1  sticky fetch-timeout flag.
- halted  out  1  sticky self-loop halt flag; constant 0 when the optional feature is out.
- retire_cnt  out  CNT_W  retired instructions, wraps.

Behaviour:
- Reset: state IDLE, instr=0, timeout counter=0, retire_cnt=0, and all single-bit outputs 0.
- Reset applied mid-operation aborts immediately and takes effect on the same edge.
- IDLE:
  - Holds while run=0.
  - run=1 → FETCH on the next edge.
- FETCH:
  - imem_req=1.
  - imem_ack=1 → latch imem_data into instr, clear the timeout counter, go to EXEC.
  - Otherwise the timeout counter increments.
  - When the counter equals FETCH_TIMEOUT-1 with no ack → FAULT.
  - ack and timeout in the same cycle: ack wins.
- EXEC:
  - instr_valid=1. Waits indefinitely for exec_done.
  - exec_done=1 → evaluate the jump, register the decision, go to UPDATE.
  - exec_done in the same cycle that instr_valid first rises is legal (1-cycle execute).
- Jump evaluation:
  - instr[15]=0 (A-instr) → no jump.
  - Otherwise jump = (instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~ng & ~zr).
  - j=3'b111 is unconditional; j=3'b000 never jumps.
- UPDATE (exactly 1 cycle):
  - Asserts pc_load if the jump is taken, else pc_inc. Never both, never neither.
  - retire_cnt increments, wrapping at 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
- Effective PC update: the PC changes on the edge ending UPDATE, so the next FETCH sees the new pc.
- Minimum instruction latency: 3 cycles (FETCH with ack, EXEC with done, UPDATE).
- run falling mid-instruction: the instruction completes through UPDATE, then IDLE.
- FAULT: imem_req=0, instr_valid=0, fault=1. Sticky until reset. run is ignored.
- Registered outputs: pc_inc, pc_load, instr_valid, imem_req are decoded from the registered state only, with no combinational path from inputs.

Optional Feature:
- Macro HACK_SELF_LOOP_HALT_EN.
- Defined: when the decision in EXEC is a taken jump with jmp_target==pc (the Hack "END: @END; 0;JMP" idiom):
  - Enter HALT instead of UPDATE.
  - No pc_load/pc_inc pulse; retire_cnt still increments once.
  - halted=1 and imem_req=0.
  - Sticky until reset.
- Undefined: the HALT state does not exist, halted is tied 0, and self-loops keep fetching forever.

Decomposition:
- Package hack_ctrl_pkg: state enum (IDLE, FETCH, EXEC, UPDATE, FAULT, HALT), jump-bit index constants (J_LT=2, J_EQ=1, J_GT=0), C-instruction flag bit index 15.
- Sub-module hack_jump_eval: combinational; inputs instr, zr, ng; output jump_taken. It is reused by the verification scoreboard.

Test Plan:
- A-instr: run=1, pc=0, ROM acks 16'h0005 in the first FETCH cycle, exec_done one cycle later → exactly one pc_inc pulse, no pc_load, retire_cnt=1, FETCH resumes.
- Conditional jump sweep: instr=16'hE302 (JEQ) with zr=1 → pc_load. Same instr with zr=0,ng=0 → pc_inc. Sweep all 8 j codes × {zr, ng, pos} against the hack_jump_eval truth table.
- Timeout: FETCH_TIMEOUT=4, imem_ack held 0 → fault=1 after exactly 4 FETCH cycles, imem_req drops. Ack arriving on the 4th cycle instead → no fault.
- Stop/resume: deassert run during EXEC → the instruction completes with one pulse, then IDLE. Reassert run → FETCH next cycle with pc unchanged.
- Reset mid-EXEC: reset asserted while instr_valid=1 → next cycle all outputs 0, retire_cnt=0, state IDLE. Wrap check: retire_cnt preset by running 65536 instructions → wraps to 0.
- With HACK_SELF_LOOP_HALT_EN: pc=16'h0010, jmp_target=16'h0010, instr=16'hEA87 → halted=1, no pc_load, imem_req stays 0. Without the macro, the same stimulus → pc_load pulse and refetch.
